word_tx_serializer: RTL and testbench

Parametrised word-to-byte transmit serializer between the RAM read path and the PC byte link. It accepts words through a valid/ready handshake into a small FIFO. Each word is emitted as DATA_W/8 byte slots, with each data byte optionally preceded by PAD_BYTES zero slots. Every slot produces one `txen` strobe, and slots are paced GAP+1 clock cycles apart. Compared with the fixed 32-bit, 3-pad, single-word sender, this block adds configurable width, padding, byte order and spacing, input buffering, overflow detection and a completion pulse.

---
 rtl/word_tx_serializer.sv | 183 ++++++++++++++++++
 tb/tb_word_tx_serializer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_tx_serializer.sv
// word_tx_serializer: buffers words from the RAM read path in a small FIFO and
// emits each word as a series of paced byte slots (optional zero pads before
// every data byte) on the txen/txpcdata byte link.
module word_tx_serializer #(
  parameter int DATA_W     = 32,
  parameter int PAD_BYTES  = 3,
  parameter int GAP        = 12432,
  parameter int MSB_FIRST  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] r_data,
  output logic              in_ready,
  output logic              txen,
  output logic [7:0]        txpcdata,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  input  logic              clr_ovf
);

  localparam int NBYTES  = DATA_W / 8;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(GAP + 1);
  localparam int PHASE_W = (PAD_BYTES > 0) ? $clog2(PAD_BYTES + 1) : 1;
  localparam int BIDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [CNT_W-1:0]   GAP_C      = CNT_W'(GAP);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PAD_BYTES);
  localparam logic [BIDX_W-1:0]  LAST_BYTE  = BIDX_W'(NBYTES - 1);
  localparam logic [PTR_W:0]     COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic              push;
  logic              pop;
  logic              ovf_reg;
  logic [DATA_W-1:0] head_word;

  // Send-side state
  state_t            state_reg;
  logic [DATA_W-1:0] word_reg;
  logic [CNT_W-1:0]  cyc_reg;
  logic [PHASE_W-1:0] phase_reg;
  logic [PHASE_W-1:0] phase_next;
  logic [BIDX_W-1:0] bidx_reg;
  logic [BIDX_W-1:0] bidx_next;
  logic              last_slot;
  logic [7:0]        first_byte;
  logic [7:0]        next_byte;
  logic              txen_reg;
  logic [7:0]        txdata_reg;
  logic              busy_reg;
  logic              done_reg;

  // Byte lanes in transmit order: lane 0 is the first data byte sent.
  logic [7:0] head_lane [NBYTES];
  logic [7:0] word_lane [NBYTES];

  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
      localparam int SRC = (MSB_FIRST != 0) ? (NBYTES - 1 - gi) : gi;
      assign head_lane[gi] = head_word[SRC*8 +: 8];
      assign word_lane[gi] = word_reg[SRC*8 +: 8];
    end
  endgenerate

  assign in_ready  = (count_reg != COUNT_FULL);
  assign push      = in_valid && in_ready;
  assign pop       = (state_reg == IDLE) && (count_reg != '0);
  assign head_word = fifo_mem[rd_ptr_reg];

  // Slot sequencing: phase walks the pads then the data byte, bidx the bytes.
  always_comb begin
    phase_next = phase_reg + 1'b1;
    bidx_next  = bidx_reg;
    if (phase_reg == LAST_PHASE) begin
      phase_next = '0;
      bidx_next  = bidx_reg + 1'b1;
    end
  end

  assign last_slot  = (phase_reg == LAST_PHASE) && (bidx_reg == LAST_BYTE);
  assign next_byte  = (phase_next == LAST_PHASE) ? word_lane[bidx_next] : 8'h00;
  // With no padding the very first slot already carries data.
  assign first_byte = (LAST_PHASE == '0) ? head_lane[0] : 8'h00;

  // FIFO storage write; contents are only ever changed by pushes.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= r_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  // Sticky overflow flag; a dropped push wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (in_valid && !in_ready) begin
      ovf_reg <= 1'b1;
    end else if (clr_ovf) begin
      ovf_reg <= 1'b0;
    end
  end

  // Transmit FSM: pop a word in IDLE, then pace its slots GAP+1 cycles apart.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      word_reg   <= '0;
      cyc_reg    <= '0;
      phase_reg  <= '0;
      bidx_reg   <= '0;
      txen_reg   <= 1'b0;
      txdata_reg <= 8'h00;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      txen_reg <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pop) begin
            word_reg   <= head_word;
            cyc_reg    <= '0;
            phase_reg  <= '0;
            bidx_reg   <= '0;
            txen_reg   <= 1'b1;
            txdata_reg <= first_byte;
            busy_reg   <= 1'b1;
            state_reg  <= SEND;
          end
        end
        SEND: begin
          if (cyc_reg == GAP_C) begin
            cyc_reg <= '0;
            if (last_slot) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= IDLE;
            end else begin
              phase_reg  <= phase_next;
              bidx_reg   <= bidx_next;
              txen_reg   <= 1'b1;
              txdata_reg <= next_byte;
            end
          end else begin
            cyc_reg <= cyc_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign txen     = txen_reg;
  assign txpcdata = txdata_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign ovf      = ovf_reg;

endmodule

// File: tb/tb_word_tx_serializer.sv
// Testbench for word_tx_serializer: three instances (LSB-first with one pad,
// MSB-first without pads, default parameters) checked against a slot timeline
// model computed from the word, padding and order rules.
module tb_word_tx_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid [3];
  logic [31:0] r_data   [3];
  logic        clr_ovf  [3];
  logic        in_ready [3];
  logic        txen     [3];
  logic [7:0]  txpcdata [3];
  logic        busy     [3];
  logic        done     [3];
  logic        ovf      [3];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Recorded events: cycle index (rising edges so far) of each txen / done.
  int          tx_cyc   [3][$];
  logic [7:0]  tx_byte  [3][$];
  int          done_cyc [3][$];
  logic [31:0] sent_q[$];
  int          push_edge_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  word_tx_serializer #(.DATA_W(32), .PAD_BYTES(1), .GAP(3), .MSB_FIRST(0), .FIFO_DEPTH(4)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .r_data(r_data[0]), .in_ready(in_ready[0]),
    .txen(txen[0]), .txpcdata(txpcdata[0]), .busy(busy[0]), .done(done[0]), .ovf(ovf[0]),
    .clr_ovf(clr_ovf[0]));

  word_tx_serializer #(.DATA_W(32), .PAD_BYTES(0), .GAP(3), .MSB_FIRST(1), .FIFO_DEPTH(4)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .r_data(r_data[1]), .in_ready(in_ready[1]),
    .txen(txen[1]), .txpcdata(txpcdata[1]), .busy(busy[1]), .done(done[1]), .ovf(ovf[1]),
    .clr_ovf(clr_ovf[1]));

  word_tx_serializer u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .r_data(r_data[2]), .in_ready(in_ready[2]),
    .txen(txen[2]), .txpcdata(txpcdata[2]), .busy(busy[2]), .done(done[2]), .ovf(ovf[2]),
    .clr_ovf(clr_ovf[2]));

  // Sample outputs on the falling edge and log every strobe and completion.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (txen[k]) begin
        tx_cyc[k].push_back(cyc);
        tx_byte[k].push_back(txpcdata[k]);
      end
      if (done[k]) done_cyc[k].push_back(cyc);
    end
  end

  // Reference: byte carried by slot 'slot' of a 32-bit word.
  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int pad,
                                          input int msb, input int slot);
    int grp = slot / (pad + 1);
    int idx = (msb != 0) ? (3 - grp) : grp;
    if ((slot % (pad + 1)) != pad) return 8'h00;
    return w[idx*8 +: 8];
  endfunction

  task automatic clear_events();
    for (int k = 0; k < 3; k++) begin
      tx_cyc[k].delete();
      tx_byte[k].delete();
      done_cyc[k].delete();
    end
    sent_q.delete();
    push_edge_q.delete();
  endtask

  task automatic push_one(input int k, input logic [31:0] w, output int pe);
    @(negedge clk);
    in_valid[k] = 1'b1;
    r_data[k]   = w;
    @(posedge clk);
    #1 pe = cyc;
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  // Offer n random words on consecutive cycles, honouring in_ready.
  task automatic drive_words(input int k, input int n, input int budget);
    logic [31:0] w;
    int c = 0;
    while (sent_q.size() < n && c < budget) begin
      @(negedge clk);
      if (in_ready[k]) begin
        w = $urandom();
        in_valid[k] = 1'b1;
        r_data[k]   = w;
        @(posedge clk);
        #1;
        sent_q.push_back(w);
        push_edge_q.push_back(cyc);
      end else begin
        in_valid[k] = 1'b0;
        c++;
      end
    end
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int n, input int budget, output bit ok);
    int c = 0;
    while (done_cyc[k].size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    ok = (done_cyc[k].size() >= n);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (txen[k] !== 1'b0 || txpcdata[k] !== 8'h00 || busy[k] !== 1'b0 || done[k] !== 1'b0 ||
          ovf[k] !== 1'b0 || in_ready[k] !== 1'b1)
        $display("FAIL reset_values[%0d]: got txen=%b data=%02h busy=%b done=%b ovf=%b rdy=%b expected 0 00 0 0 0 1",
                 k, txen[k], txpcdata[k], busy[k], done[k], ovf[k], in_ready[k]);
      else n_pass++;
    end
  endtask

  // One word at a time through an instance with GAP=3 (4 cycles per slot).
  task automatic test_single(input int k, input int pad, input int msb);
    logic [31:0] w;
    int pe;
    int sl = 4 * (pad + 1);
    bit ok;
    for (int r = 0; r < 3; r++) begin
      w = (r == 0) ? 32'hA1B2C3D4 : $urandom();
      clear_events();
      push_one(k, w, pe);
      wait_done(k, 1, 200, ok);
      n_total++;
      if (!ok) $display("FAIL single%0d_done_timeout: got %0d done pulses expected 1", k, done_cyc[k].size());
      else n_pass++;
      n_total++;
      if (tx_cyc[k].size() != sl) $display("FAIL single%0d_strobe_count: got %0d expected %0d", k, tx_cyc[k].size(), sl);
      else n_pass++;
      for (int s = 0; s < tx_cyc[k].size() && s < sl; s++) begin
        n_total++;
        if (tx_byte[k][s] !== exp_byte(w, pad, msb, s) || tx_cyc[k][s] != pe + 1 + 4 * s)
          $display("FAIL single%0d_slot[%0d]: got %02h at cycle %0d expected %02h at cycle %0d",
                   k, s, tx_byte[k][s], tx_cyc[k][s], exp_byte(w, pad, msb, s), pe + 1 + 4 * s);
        else n_pass++;
      end
      if (ok) begin
        n_total++;
        if (done_cyc[k][0] != pe + 1 + 4 * sl)
          $display("FAIL single%0d_done_time: got cycle %0d expected %0d", k, done_cyc[k][0], pe + 1 + 4 * sl);
        else n_pass++;
      end
      n_total++;
      if (busy[k] !== 1'b0 || txpcdata[k] !== exp_byte(w, pad, msb, sl - 1))
        $display("FAIL single%0d_idle_after: got busy=%b data=%02h expected 0 %02h",
                 k, busy[k], txpcdata[k], exp_byte(w, pad, msb, sl - 1));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    int idx;
    bit ok;
    clear_events();
    drive_words(0, 5, 20);
    n_total++;
    if (sent_q.size() != 5 || push_edge_q[4] != push_edge_q[0] + 4)
      $display("FAIL b2b_accept: got %0d words over %0d edges expected 5 over 4",
               sent_q.size(), push_edge_q[push_edge_q.size() - 1] - push_edge_q[0]);
    else n_pass++;
    n_total++;
    if (in_ready[0] !== 1'b0 || ovf[0] !== 1'b0)
      $display("FAIL b2b_full: got in_ready=%b ovf=%b expected 0 0", in_ready[0], ovf[0]);
    else n_pass++;
    wait_done(0, 5, 400, ok);
    n_total++;
    if (!ok || tx_cyc[0].size() != 40)
      $display("FAIL b2b_counts: got %0d done %0d strobes expected 5 40", done_cyc[0].size(), tx_cyc[0].size());
    else n_pass++;
    t0 = push_edge_q[0] + 1;
    for (int i = 0; i < 5; i++) begin
      for (int s = 0; s < 8; s++) begin
        idx = i * 8 + s;
        if (idx < tx_cyc[0].size()) begin
          n_total++;
          if (tx_byte[0][idx] !== exp_byte(sent_q[i], 1, 0, s) || tx_cyc[0][idx] != t0 + i * 33 + s * 4)
            $display("FAIL b2b_slot[%0d]: got %02h at cycle %0d expected %02h at cycle %0d", idx,
                     tx_byte[0][idx], tx_cyc[0][idx], exp_byte(sent_q[i], 1, 0, s), t0 + i * 33 + s * 4);
          else n_pass++;
        end
      end
      if (i < done_cyc[0].size()) begin
        n_total++;
        if (done_cyc[0][i] != t0 + i * 33 + 32)
          $display("FAIL b2b_done[%0d]: got cycle %0d expected %0d", i, done_cyc[0][i], t0 + i * 33 + 32);
        else n_pass++;
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    int idx;
    clear_events();
    drive_words(0, 5, 20);
    n_total++;
    if (in_ready[0] !== 1'b0) $display("FAIL ovf_full: got in_ready=%b expected 0", in_ready[0]);
    else n_pass++;
    in_valid[0] = 1'b1;
    r_data[0]   = 32'hDEADBEEF;
    @(negedge clk);
    n_total++;
    if (ovf[0] !== 1'b1) $display("FAIL ovf_set: got %b expected 1", ovf[0]);
    else n_pass++;
    @(negedge clk);
    in_valid[0] = 1'b0;
    clr_ovf[0]  = 1'b1;
    @(negedge clk);
    clr_ovf[0] = 1'b0;
    n_total++;
    if (ovf[0] !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", ovf[0]);
    else n_pass++;
    in_valid[0] = 1'b1;
    clr_ovf[0]  = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    clr_ovf[0]  = 1'b0;
    n_total++;
    if (ovf[0] !== 1'b1) $display("FAIL ovf_set_beats_clear: got %b expected 1", ovf[0]);
    else n_pass++;
    clr_ovf[0] = 1'b1;
    @(negedge clk);
    clr_ovf[0] = 1'b0;
    n_total++;
    if (ovf[0] !== 1'b0) $display("FAIL ovf_clear2: got %b expected 0", ovf[0]);
    else n_pass++;
    wait_done(0, 5, 400, ok);
    repeat (40) @(negedge clk);
    n_total++;
    if (!ok || tx_cyc[0].size() != 40 || done_cyc[0].size() != 5)
      $display("FAIL ovf_sequence_len: got %0d strobes %0d done expected 40 5", tx_cyc[0].size(), done_cyc[0].size());
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      for (int s = 0; s < 8; s++) begin
        idx = i * 8 + s;
        if (idx < tx_byte[0].size()) begin
          n_total++;
          if (tx_byte[0][idx] !== exp_byte(sent_q[i], 1, 0, s))
            $display("FAIL ovf_slot[%0d]: got %02h expected %02h", idx, tx_byte[0][idx], exp_byte(sent_q[i], 1, 0, s));
          else n_pass++;
        end
      end
    end
  endtask

  // Default parameters: first four slots, then a reset in the middle of the word.
  task automatic test_defaults_and_midword_reset();
    logic [31:0] w = 32'h12345678;
    int pe;
    int c = 0;
    int ntx;
    int ndone;
    clear_events();
    push_one(2, w, pe);
    while (tx_cyc[2].size() < 4 && c < 40000) begin
      @(negedge clk);
      c++;
    end
    n_total++;
    if (tx_cyc[2].size() < 4) $display("FAIL def_timeout: got %0d strobes expected 4", tx_cyc[2].size());
    else n_pass++;
    for (int s = 0; s < tx_cyc[2].size() && s < 4; s++) begin
      n_total++;
      if (tx_byte[2][s] !== exp_byte(w, 3, 0, s) || tx_cyc[2][s] != pe + 1 + 12433 * s)
        $display("FAIL def_slot[%0d]: got %02h at cycle %0d expected %02h at cycle %0d",
                 s, tx_byte[2][s], tx_cyc[2][s], exp_byte(w, 3, 0, s), pe + 1 + 12433 * s);
      else n_pass++;
    end
    n_total++;
    if (busy[2] !== 1'b1) $display("FAIL def_busy: got %b expected 1", busy[2]);
    else n_pass++;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (txen[2] !== 1'b0 || txpcdata[2] !== 8'h00 || busy[2] !== 1'b0 || done[2] !== 1'b0 ||
        ovf[2] !== 1'b0 || in_ready[2] !== 1'b1)
      $display("FAIL midword_reset: got txen=%b data=%02h busy=%b done=%b ovf=%b rdy=%b expected 0 00 0 0 0 1",
               txen[2], txpcdata[2], busy[2], done[2], ovf[2], in_ready[2]);
    else n_pass++;
    ntx   = tx_cyc[2].size();
    ndone = done_cyc[2].size();
    repeat (13000) @(negedge clk);
    n_total++;
    if (tx_cyc[2].size() != ntx || done_cyc[2].size() != ndone || busy[2] !== 1'b0)
      $display("FAIL midword_quiet: got %0d new strobes %0d new done busy=%b expected 0 0 0",
               tx_cyc[2].size() - ntx, done_cyc[2].size() - ndone, busy[2]);
    else n_pass++;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0;
      r_data[k]   = 32'h0;
      clr_ovf[k]  = 1'b0;
    end
    test_reset();
    test_single(0, 1, 0);
    test_single(1, 0, 1);
    test_back_to_back();
    test_overflow();
    test_defaults_and_midword_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
